vblank_scheduler: RTL and testbench

Sequences per-frame game-logic updates into the vertical blanking interval of the 640x480 VGA raster. It watches the raster counters `colPos` and `rowPos` from the VGA timing generator and detects the start of vblank. It then grants exclusive update slots, one at a time in fixed priority order, to up to NUM_CLIENTS requesters (frog, car lanes, score) using a start/done handshake. It also maintains a frame counter and flags deadline overruns and hung clients.

---
 rtl/vblank_scheduler_if.sv | 30 +++
 rtl/vblank_scheduler.sv | 116 +++++++++++
 tb/tb_vblank_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vblank_scheduler_if.sv
// Raster, request and grant signals between the vblank scheduler
// and the game-logic clients it sequences.
interface vblank_scheduler_if #(
    parameter int NUM_CLIENTS = 4
);
    logic [9:0]             colPos;
    logic [9:0]             rowPos;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] done;
    logic                   clearFlags;
    logic [NUM_CLIENTS-1:0] grant;
    logic [NUM_CLIENTS-1:0] start;
    logic                   frameTick;
    logic [15:0]            frameCount;
    logic                   busy;
    logic                   overrun;
    logic                   timeout;

    modport master (
        input  colPos, rowPos, req, done, clearFlags,
        output grant, start, frameTick, frameCount,
        output busy, overrun, timeout
    );

    modport slave (
        output colPos, rowPos, req, done, clearFlags,
        input  grant, start, frameTick, frameCount,
        input  busy, overrun, timeout
    );
endinterface

// File: rtl/vblank_scheduler.sv
// Grants one client update slot at a time during vertical blanking,
// counts frames and flags deadline overruns and hung clients.
module vblank_scheduler #(
    parameter int NUM_CLIENTS      = 4,
    parameter int VBLANK_START_ROW = 480,
    parameter int TIMEOUT_CYCLES   = 8000
) (
    input  logic               clk,
    input  logic               rst,
    vblank_scheduler_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT
    } state_t;

    state_t                 state_q;
    logic [NUM_CLIENTS-1:0] pending_q;
    logic [NUM_CLIENTS-1:0] grant_q;
    logic [NUM_CLIENTS-1:0] start_q;
    logic [TW-1:0]          timer_q;
    logic [15:0]            frame_q;
    logic                   tick_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic                   trig;
    logic                   dl;
    logic                   done_hit;
    logic                   time_hit;
    logic [NUM_CLIENTS-1:0] sel_oh;

    assign trig = (bus.colPos == 10'd0)
               && (bus.rowPos == 10'(VBLANK_START_ROW));
    assign dl   = (bus.colPos == 10'd0) && (bus.rowPos == 10'd0);

    // Lowest set bit of pending gives the fixed-priority winner
    assign sel_oh   = pending_q & (~pending_q + ONE);
    assign done_hit = |(bus.done & grant_q);
    assign time_hit = (timer_q == TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            start_q   <= '0;
            timer_q   <= '0;
            frame_q   <= '0;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tick_q  <= trig;
            start_q <= '0;
            if (trig) begin
                frame_q <= frame_q + 16'd1;
            end
            if (bus.clearFlags) begin
                overrun_q <= 1'b0;
                timeout_q <= 1'b0;
            end
            // Active video resuming cuts off whatever is still scheduled
            if (dl && state_q != IDLE) begin
                grant_q   <= '0;
                pending_q <= '0;
                state_q   <= IDLE;
                overrun_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (trig) begin
                            pending_q <= bus.req;
                            state_q   <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (pending_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            grant_q <= sel_oh;
                            start_q <= sel_oh;
                            timer_q <= '0;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        timer_q <= timer_q + TW'(1);
                        if (done_hit || time_hit) begin
                            grant_q   <= '0;
                            pending_q <= pending_q & ~grant_q;
                            state_q   <= SELECT;
                            if (!done_hit) begin
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.start      = start_q;
    assign bus.frameTick  = tick_q;
    assign bus.frameCount = frame_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: sequencing, empty frame,
// reset, timeout, overrun, stray done and frame counter wrap.
module tb_vblank_scheduler;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    vblank_scheduler_if #(.NUM_CLIENTS(4)) bus ();

    vblank_scheduler #(
        .NUM_CLIENTS     (4),
        .VBLANK_START_ROW(480),
        .TIMEOUT_CYCLES  (8000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic trig_on();
        bus.rowPos = 10'd480;
        bus.colPos = 10'd0;
    endtask

    task automatic raster_off();
        bus.rowPos = 10'd481;
        bus.colPos = 10'd5;
    endtask

    // Called on the cycle the slot's grant first shows
    task automatic serve(input logic [3:0] b);
        check("start_on", bus.start, b);
        check("grant_on", bus.grant, b);
        step();
        check("start_pulse", bus.start, 0);
        bus.done = ~b;
        step();
        bus.done = '0;
        check("stray_done", bus.grant, b);
        repeat (7) step();
        bus.done = b;
        step();
        bus.done = '0;
        check("release", bus.grant, 0);
        check("busy_gap", bus.busy, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.done = '0;
        bus.clearFlags = 1'b0;
        raster_off();
        repeat (2) step();

        check("rst_grant", bus.grant, 0);
        check("rst_start", bus.start, 0);
        check("rst_tick", bus.frameTick, 0);
        check("rst_count", bus.frameCount, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_timeout", bus.timeout, 0);
        rst = 1'b0;
        step();

        // basic sequence: clients 0, 1, 3
        bus.req = 4'b1011;
        trig_on();
        step();
        check("b_tick", bus.frameTick, 1);
        check("b_count", bus.frameCount, 1);
        check("b_busy", bus.busy, 1);
        check("b_grant_t1", bus.grant, 0);
        bus.req = '0;
        raster_off();
        step();
        check("b_tick_off", bus.frameTick, 0);
        serve(4'b0001);
        step();
        serve(4'b0010);
        step();
        serve(4'b1000);
        step();
        check("b_busy_end", bus.busy, 0);
        check("b_grant_end", bus.grant, 0);
        check("b_overrun", bus.overrun, 0);
        check("b_timeout", bus.timeout, 0);

        // empty frame
        trig_on();
        step();
        check("e_tick", bus.frameTick, 1);
        check("e_count", bus.frameCount, 2);
        check("e_busy", bus.busy, 1);
        raster_off();
        step();
        check("e_busy_off", bus.busy, 0);
        check("e_grant", bus.grant, 0);
        check("e_start", bus.start, 0);

        // reset while client 1 holds its slot
        bus.req = 4'b0011;
        trig_on();
        step();
        raster_off();
        step();
        check("r_grant0", bus.grant, 4'b0001);
        bus.done = 4'b0001;
        step();
        bus.done = '0;
        step();
        check("r_grant1", bus.grant, 4'b0010);
        check("r_count_pre", bus.frameCount, 3);
        rst = 1'b1;
        #1;
        check("r_async_grant", bus.grant, 0);
        check("r_async_start", bus.start, 0);
        check("r_async_busy", bus.busy, 0);
        check("r_async_count", bus.frameCount, 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("r_post_grant", bus.grant, 0);
        check("r_post_start", bus.start, 0);
        check("r_post_busy", bus.busy, 0);

        // timeout on client 0
        bus.req = 4'b0001;
        trig_on();
        step();
        raster_off();
        bus.req = '0;
        step();
        check("t_grant_on", bus.grant, 4'b0001);
        repeat (7999) step();
        check("t_grant_held", bus.grant, 4'b0001);
        check("t_flag_pre", bus.timeout, 0);
        step();
        check("t_grant_drop", bus.grant, 0);
        check("t_flag", bus.timeout, 1);
        step();
        check("t_busy_end", bus.busy, 0);
        bus.clearFlags = 1'b1;
        step();
        bus.clearFlags = 1'b0;
        check("t_flag_clr", bus.timeout, 0);

        // overrun: deadline while client 2 holds, clear coincides
        bus.req = 4'b0100;
        trig_on();
        step();
        raster_off();
        step();
        check("o_grant_on", bus.grant, 4'b0100);
        repeat (5) step();
        bus.rowPos = 10'd0;
        bus.colPos = 10'd0;
        bus.clearFlags = 1'b1;
        step();
        bus.clearFlags = 1'b0;
        raster_off();
        check("o_grant", bus.grant, 0);
        check("o_busy", bus.busy, 0);
        check("o_flag", bus.overrun, 1);
        bus.req = 4'b0001;
        trig_on();
        step();
        raster_off();
        bus.req = '0;
        step();
        check("o_next_grant", bus.grant, 4'b0001);
        check("o_flag_kept", bus.overrun, 1);
        bus.done = 4'b0001;
        step();
        bus.done = '0;
        step();
        check("o_next_busy", bus.busy, 0);
        bus.clearFlags = 1'b1;
        step();
        bus.clearFlags = 1'b0;
        check("o_flag_clr", bus.overrun, 0);

        // frame counter wrap: count is 3 here
        check("w_count_pre", bus.frameCount, 3);
        trig_on();
        repeat (65532) step();
        check("w_count_max", bus.frameCount, 16'hFFFF);
        step();
        check("w_count_wrap", bus.frameCount, 0);
        raster_off();
        step();
        check("w_tick_off", bus.frameTick, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
